// File: rtl/arithmetic_logic_unit_pkg.sv
// Shared definitions for the decoder, reservation station and execute unit.
// Holds the width constants and the internal opcode encoding.
package arithmetic_logic_unit_pkg;

    localparam int DataLength   = 31;
    localparam int PcLength     = 31;
    localparam int OpcodeLength = 5;
    localparam int Zero         = 0;

    // Internal opcode. Codes 30 and above are loads/stores. They are handled
    // by the memory pipe and never issue to the ALU.
    typedef enum logic [OpcodeLength:0] {
        OP_NOP   = 6'd0,
        OP_LUI   = 6'd1,
        OP_AUIPC = 6'd2,
        OP_JAL   = 6'd3,
        OP_JALR  = 6'd4,
        OP_BEQ   = 6'd5,
        OP_BNE   = 6'd6,
        OP_BLT   = 6'd7,
        OP_BGE   = 6'd8,
        OP_BLTU  = 6'd9,
        OP_BGEU  = 6'd10,
        OP_ADDI  = 6'd11,
        OP_SLTI  = 6'd12,
        OP_SLTIU = 6'd13,
        OP_XORI  = 6'd14,
        OP_ORI   = 6'd15,
        OP_ANDI  = 6'd16,
        OP_SLLI  = 6'd17,
        OP_SRLI  = 6'd18,
        OP_SRAI  = 6'd19,
        OP_ADD   = 6'd20,
        OP_SUB   = 6'd21,
        OP_SLL   = 6'd22,
        OP_SLT   = 6'd23,
        OP_SLTU  = 6'd24,
        OP_XOR   = 6'd25,
        OP_SRL   = 6'd26,
        OP_SRA   = 6'd27,
        OP_OR    = 6'd28,
        OP_AND   = 6'd29
    } opcode_t;

endpackage

// File: rtl/arithmetic_logic_unit_branch_cmp.sv
// Branch condition evaluation. This block is purely combinational.
// Ports:
//   v1, v2 : rs1/rs2 operands
//   op     : internal opcode
//   taken  : 1 when op is a branch and its condition holds. 0 for any non-branch op.
module alu_branch_cmp
    import arithmetic_logic_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] v1,
    input  logic [DATA_W-1:0] v2,
    input  opcode_t           op,
    output logic              taken
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (v1 == v2);
    assign lt_s = ($signed(v1) < $signed(v2));
    assign lt_u = (v1 < v2);

    always_comb begin
        taken = 1'b0;
        case (op)
            OP_BEQ:  taken = eq;
            OP_BNE:  taken = !eq;
            OP_BLT:  taken = lt_s;
            OP_BGE:  taken = !lt_s;
            OP_BLTU: taken = lt_u;
            OP_BGEU: taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/arithmetic_logic_unit.sv
// Single-cycle integer execute unit. Each cycle it accepts one issued non-memory
// instruction and registers the result, the tag and the next PC. The ROB sees
// these values one cycle later. There is no stall path and no flush path.
// Ports:
//   clk, rst          : clock; asynchronous active-low reset
//   is_empty_from_rs  : 1 = nothing issued this cycle
//   op_from_rs        : internal opcode
//   v1/v2_from_rs     : rs1/rs2 values
//   imm_from_rs       : sign-extended immediate (U-type already shifted)
//   pc_from_rs        : instruction address, also used as the ROB tag
//   is_finish_to_rob  : one-cycle pulse for each issued instruction
//   data_to_rob       : result value
//   pc_to_rob         : tag echo
//   jpc_to_rob        : architecturally correct next PC
module arithmetic_logic_unit
    import arithmetic_logic_unit_pkg::*;
#(
    parameter int DATA_W = DataLength + 1,
    parameter int PC_W   = PcLength + 1,
    parameter int OP_W   = OpcodeLength + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              is_empty_from_rs,
    input  logic [OP_W-1:0]   op_from_rs,
    input  logic [DATA_W-1:0] v1_from_rs,
    input  logic [DATA_W-1:0] v2_from_rs,
    input  logic [DATA_W-1:0] imm_from_rs,
    input  logic [PC_W-1:0]   pc_from_rs,
    output logic              is_finish_to_rob,
    output logic [DATA_W-1:0] data_to_rob,
    output logic [PC_W-1:0]   pc_to_rob,
    output logic [PC_W-1:0]   jpc_to_rob
);

    opcode_t           op;
    logic              taken;
    logic [PC_W-1:0]   pc_plus4;
    logic [PC_W-1:0]   pc_imm;
    logic [DATA_W-1:0] v1_imm;
    logic [4:0]        sh_imm;
    logic [4:0]        sh_reg;
    logic [DATA_W-1:0] result;
    logic [PC_W-1:0]   next_pc;

    assign op       = opcode_t'(op_from_rs);
    assign pc_plus4 = pc_from_rs + PC_W'(4);
    assign pc_imm   = pc_from_rs + PC_W'(imm_from_rs);
    assign v1_imm   = v1_from_rs + imm_from_rs;
    assign sh_imm   = imm_from_rs[4:0];
    assign sh_reg   = v2_from_rs[4:0];

    alu_branch_cmp #(.DATA_W(DATA_W)) u_branch_cmp (
        .v1    (v1_from_rs),
        .v2    (v2_from_rs),
        .op    (op),
        .taken (taken)
    );

    always_comb begin
        result  = '0;
        next_pc = pc_plus4;
        case (op)
            OP_LUI:   result = imm_from_rs;
            OP_AUIPC: result = DATA_W'(pc_imm);
            OP_JAL: begin
                result  = DATA_W'(pc_plus4);
                next_pc = pc_imm;
            end
            OP_JALR: begin
                result  = DATA_W'(pc_plus4);
                next_pc = PC_W'(v1_imm) & ~PC_W'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                result  = DATA_W'(taken);
                next_pc = taken ? pc_imm : pc_plus4;
            end
            OP_ADDI:  result = v1_imm;
            OP_SLTI:  result = DATA_W'($signed(v1_from_rs) < $signed(imm_from_rs));
            OP_SLTIU: result = DATA_W'(v1_from_rs < imm_from_rs);
            OP_XORI:  result = v1_from_rs ^ imm_from_rs;
            OP_ORI:   result = v1_from_rs | imm_from_rs;
            OP_ANDI:  result = v1_from_rs & imm_from_rs;
            OP_SLLI:  result = v1_from_rs << sh_imm;
            OP_SRLI:  result = v1_from_rs >> sh_imm;
            OP_SRAI:  result = DATA_W'($signed(v1_from_rs) >>> sh_imm);
            OP_ADD:   result = v1_from_rs + v2_from_rs;
            OP_SUB:   result = v1_from_rs - v2_from_rs;
            OP_SLL:   result = v1_from_rs << sh_reg;
            OP_SLT:   result = DATA_W'($signed(v1_from_rs) < $signed(v2_from_rs));
            OP_SLTU:  result = DATA_W'(v1_from_rs < v2_from_rs);
            OP_XOR:   result = v1_from_rs ^ v2_from_rs;
            OP_SRL:   result = v1_from_rs >> sh_reg;
            OP_SRA:   result = DATA_W'($signed(v1_from_rs) >>> sh_reg);
            OP_OR:    result = v1_from_rs | v2_from_rs;
            OP_AND:   result = v1_from_rs & v2_from_rs;
            // NOP and unknown codes still finish, with result 0 and next PC pc+4.
            default:  result = '0;
        endcase
    end

    // An empty cycle drops finish and keeps the last broadcast values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_finish_to_rob <= 1'b0;
            data_to_rob      <= '0;
            pc_to_rob        <= '0;
            jpc_to_rob       <= '0;
        end else if (!is_empty_from_rs) begin
            is_finish_to_rob <= 1'b1;
            data_to_rob      <= result;
            pc_to_rob        <= pc_from_rs;
            jpc_to_rob       <= next_pc;
        end else begin
            is_finish_to_rob <= 1'b0;
        end
    end

endmodule

// File: tb/tb_arithmetic_logic_unit.sv
module tb_arithmetic_logic_unit;
    import arithmetic_logic_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        empty;
    logic [5:0]  op;
    logic [31:0] v1, v2, imm, pc;
    logic        fin;
    logic [31:0] data, pc_o, jpc;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          op;
        logic [31:0] v1, v2, imm, pc, d, j;
    } vec_t;

    arithmetic_logic_unit dut (
        .clk              (clk),
        .rst              (rst),
        .is_empty_from_rs (empty),
        .op_from_rs       (op),
        .v1_from_rs       (v1),
        .v2_from_rs       (v2),
        .imm_from_rs      (imm),
        .pc_from_rs       (pc),
        .is_finish_to_rob (fin),
        .data_to_rob      (data),
        .pc_to_rob        (pc_o),
        .jpc_to_rob       (jpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model built from the instruction rules, using integer arithmetic.
    function automatic void model(input int o, input logic [31:0] a, b, im, p,
                                  output logic [31:0] d, output logic [31:0] j);
        int  sa = a;
        int  sb = b;
        int  si = im;
        bit  tk;
        int  sh;
        d = 32'd0;
        j = p + 32'd4;
        case (o)
            1: d = im;
            2: d = p + im;
            3: begin d = p + 32'd4; j = p + im; end
            4: begin d = p + 32'd4; j = (a + im) & 32'hFFFF_FFFE; end
            5, 6, 7, 8, 9, 10: begin
                case (o)
                    5:  tk = (a == b);
                    6:  tk = (a != b);
                    7:  tk = (sa < sb);
                    8:  tk = (sa >= sb);
                    9:  tk = (a < b);
                    default: tk = (a >= b);
                endcase
                d = {31'd0, tk};
                if (tk) j = p + im;
            end
            11: d = a + im;
            12: d = (sa < si) ? 32'd1 : 32'd0;
            13: d = (a < im) ? 32'd1 : 32'd0;
            14: d = a ^ im;
            15: d = a | im;
            16: d = a & im;
            17: begin sh = int'(im[4:0]); d = 32'(longint'(a) * (longint'(1) << sh)); end
            18: begin sh = int'(im[4:0]); d = 32'(longint'(a) / (longint'(1) << sh)); end
            19: begin sh = int'(im[4:0]); d = 32'(longint'(sa) >>> sh); end
            20: d = a + b;
            21: d = a - b;
            22: begin sh = int'(b[4:0]); d = 32'(longint'(a) * (longint'(1) << sh)); end
            23: d = (sa < sb) ? 32'd1 : 32'd0;
            24: d = (a < b) ? 32'd1 : 32'd0;
            25: d = a ^ b;
            26: begin sh = int'(b[4:0]); d = 32'(longint'(a) / (longint'(1) << sh)); end
            27: begin sh = int'(b[4:0]); d = 32'(longint'(sa) >>> sh); end
            28: d = a | b;
            29: d = a & b;
            default: d = 32'd0;
        endcase
    endfunction

    function automatic vec_t mk(int o, logic [31:0] a, b, im, p, d, j);
        vec_t t;
        t.op = o; t.v1 = a; t.v2 = b; t.imm = im; t.pc = p; t.d = d; t.j = j;
        return t;
    endfunction

    task automatic drive(vec_t t);
        empty = 1'b0;
        op    = 6'(t.op);
        v1    = t.v1;
        v2    = t.v2;
        imm   = t.imm;
        pc    = t.pc;
    endtask

    // This task issues one instruction, then stops issuing. It returns at the negedge
    // after the capture edge, when the result is on the outputs.
    task automatic run_one(vec_t t);
        @(negedge clk);
        drive(t);
        @(negedge clk);
        empty = 1'b1;
    endtask

    task automatic test_reset;
        vec_t t;
        @(negedge clk);
        n_checks++;
        if ({fin, data, pc_o, jpc} !== 97'd0) begin
            n_fail++;
            $display("FAIL reset_state: got fin=%b data=%h pc=%h jpc=%h, want all 0", fin, data, pc_o, jpc);
        end
        rst = 1'b1;
        t = mk(20, 32'd1, 32'd2, 32'd0, 32'h80, 32'd3, 32'h84);
        run_one(t);
        // Reassert reset mid-stream, away from any clock edge.
        drive(t);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({fin, data, pc_o, jpc} !== 97'd0) begin
            n_fail++;
            $display("FAIL reset_async: got fin=%b data=%h pc=%h jpc=%h, want all 0", fin, data, pc_o, jpc);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({fin, data, pc_o, jpc} !== 97'd0) begin
            n_fail++;
            $display("FAIL reset_held: got fin=%b data=%h pc=%h jpc=%h, want all 0", fin, data, pc_o, jpc);
        end
        @(negedge clk);
        empty = 1'b1;
        rst   = 1'b1;
        @(negedge clk);
        n_checks++;
        if (fin !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_nofinish: got fin=%b, want 0", fin);
        end
    endtask

    task automatic test_arith_shift;
        vec_t q[$];
        q.push_back(mk(20, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'h40, 32'h8000_0000, 32'h44));
        q.push_back(mk(21, 32'd0, 32'd1, 32'd0, 32'h48, 32'hFFFF_FFFF, 32'h4C));
        q.push_back(mk(19, 32'h8000_0000, 32'd0, 32'd4, 32'h50, 32'hF800_0000, 32'h54));
        q.push_back(mk(18, 32'h8000_0000, 32'd0, 32'd4, 32'h54, 32'h0800_0000, 32'h58));
        q.push_back(mk(23, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h58, 32'd1, 32'h5C));
        q.push_back(mk(24, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h5C, 32'd0, 32'h60));
        q.push_back(mk(20, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFC, 32'd2, 32'd0));
        foreach (q[i]) begin
            run_one(q[i]);
            n_checks++;
            if ({fin, data, pc_o, jpc} !== {1'b1, q[i].d, q[i].pc, q[i].j}) begin
                n_fail++;
                $display("FAIL arith_shift[%0d]: got fin=%b data=%h pc=%h jpc=%h, want fin=1 data=%h pc=%h jpc=%h",
                         i, fin, data, pc_o, jpc, q[i].d, q[i].pc, q[i].j);
            end
        end
    endtask

    task automatic test_branch;
        vec_t q[$];
        q.push_back(mk(5,  32'd5, 32'd5, 32'hFFFF_FFF8, 32'h100, 32'd1, 32'hF8));
        q.push_back(mk(6,  32'd5, 32'd5, 32'hFFFF_FFF8, 32'h100, 32'd0, 32'h104));
        q.push_back(mk(10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 32'd1, 32'hF8));
        q.push_back(mk(8,  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 32'd0, 32'h104));
        q.push_back(mk(9,  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 32'd0, 32'h104));
        q.push_back(mk(7,  32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFF8, 32'h100, 32'd1, 32'hF8));
        foreach (q[i]) begin
            run_one(q[i]);
            n_checks++;
            if ({fin, data, pc_o, jpc} !== {1'b1, q[i].d, q[i].pc, q[i].j}) begin
                n_fail++;
                $display("FAIL branch[%0d]: got fin=%b data=%h pc=%h jpc=%h, want fin=1 data=%h pc=%h jpc=%h",
                         i, fin, data, pc_o, jpc, q[i].d, q[i].pc, q[i].j);
            end
        end
    endtask

    task automatic test_jump_upper;
        vec_t q[$];
        q.push_back(mk(3,  32'd0, 32'd0, 32'h10, 32'h200, 32'h204, 32'h210));
        q.push_back(mk(4,  32'h1001, 32'd0, 32'd2, 32'h200, 32'h204, 32'h1002));
        q.push_back(mk(2,  32'd0, 32'd0, 32'h1000, 32'h200, 32'h1200, 32'h204));
        q.push_back(mk(1,  32'd0, 32'd0, 32'hABCD_E000, 32'h200, 32'hABCD_E000, 32'h204));
        q.push_back(mk(0,  32'h55, 32'h66, 32'h77, 32'h200, 32'd0, 32'h204));
        q.push_back(mk(40, 32'h55, 32'h66, 32'h77, 32'h208, 32'd0, 32'h20C));
        foreach (q[i]) begin
            run_one(q[i]);
            n_checks++;
            if ({fin, data, pc_o, jpc} !== {1'b1, q[i].d, q[i].pc, q[i].j}) begin
                n_fail++;
                $display("FAIL jump_upper[%0d]: got fin=%b data=%h pc=%h jpc=%h, want fin=1 data=%h pc=%h jpc=%h",
                         i, fin, data, pc_o, jpc, q[i].d, q[i].pc, q[i].j);
            end
        end
    endtask

    task automatic test_back_to_back;
        vec_t q[$];
        q.push_back(mk(11, 32'd10, 32'd0, 32'd1, 32'h300, 32'd11, 32'h304));
        q.push_back(mk(11, 32'd20, 32'd0, 32'hFFFF_FFFF, 32'h304, 32'd19, 32'h308));
        q.push_back(mk(11, 32'd30, 32'd0, 32'd5, 32'h308, 32'd35, 32'h30C));
        @(negedge clk);
        drive(q[0]);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i < 2) drive(q[i+1]);
            else       empty = 1'b1;
            n_checks++;
            if ({fin, data, pc_o, jpc} !== {1'b1, q[i].d, q[i].pc, q[i].j}) begin
                n_fail++;
                $display("FAIL back_to_back[%0d]: got fin=%b data=%h pc=%h jpc=%h, want fin=1 data=%h pc=%h jpc=%h",
                         i, fin, data, pc_o, jpc, q[i].d, q[i].pc, q[i].j);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({fin, data, pc_o, jpc} !== {1'b0, q[2].d, q[2].pc, q[2].j}) begin
            n_fail++;
            $display("FAIL back_to_back_idle: got fin=%b data=%h pc=%h jpc=%h, want fin=0 data=%h pc=%h jpc=%h",
                     fin, data, pc_o, jpc, q[2].d, q[2].pc, q[2].j);
        end
    endtask

    task automatic test_random;
        logic        e_fin;
        logic [31:0] e_d, e_pc, e_j;
        vec_t        t;
        e_fin = 1'b0; e_d = '0; e_pc = '0; e_j = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (i > 0) begin
                n_checks++;
                if ({fin, data, pc_o, jpc} !== {e_fin, e_d, e_pc, e_j}) begin
                    n_fail++;
                    $display("FAIL random[%0d]: got fin=%b data=%h pc=%h jpc=%h, want fin=%b data=%h pc=%h jpc=%h",
                             i, fin, data, pc_o, jpc, e_fin, e_d, e_pc, e_j);
                end
            end
            if (i == 0 || $urandom_range(0, 3) != 0) begin
                t.op  = int'($urandom_range(0, 33));
                t.v1  = $urandom;
                t.v2  = ($urandom_range(0, 3) == 0) ? t.v1 : $urandom;
                t.imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 4095)) - 2048);
                t.pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
                model(t.op, t.v1, t.v2, t.imm, t.pc, e_d, e_j);
                e_pc  = t.pc;
                e_fin = 1'b1;
                drive(t);
            end else begin
                empty = 1'b1;
                op    = 6'($urandom);
                v1    = $urandom;
                e_fin = 1'b0;
            end
        end
        @(negedge clk);
        empty = 1'b1;
        n_checks++;
        if ({fin, data, pc_o, jpc} !== {e_fin, e_d, e_pc, e_j}) begin
            n_fail++;
            $display("FAIL random_last: got fin=%b data=%h pc=%h jpc=%h, want fin=%b data=%h pc=%h jpc=%h",
                     fin, data, pc_o, jpc, e_fin, e_d, e_pc, e_j);
        end
    endtask

    initial begin
        rst = 1'b0; empty = 1'b1; op = '0; v1 = '0; v2 = '0; imm = '0; pc = '0;
        repeat (2) @(negedge clk);
        test_reset;
        test_arith_shift;
        test_branch;
        test_jump_upper;
        test_back_to_back;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
